// File: rtl/evg_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evg_event_pkg
// Purpose  : Shared event-code types and constants for the event generator
//            transmit path (arbiter, sequencer and trigger blocks).
// Revision : 1.0 - initial release
// ============================================================================
package evg_event_pkg;

  // Default event code width on the transmit link
  localparam int EVENTCODE_WIDTH = 8;

  // Code 0 never reaches the link; it marks "no event"
  localparam logic [EVENTCODE_WIDTH-1:0] EVCODE_NULL = '0;

  typedef logic [EVENTCODE_WIDTH-1:0] eventCode_t;

  // Arbitration mode as seen by the picker
  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arbMode_t;

  // True when a code carries an actual event
  function automatic logic isEventCode(input eventCode_t code);
    return code != EVCODE_NULL;
  endfunction

endpackage : evg_event_pkg
`default_nettype wire

// File: rtl/evg_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : evg_rr_picker
// Purpose  : Combinational rotate-and-priority-encode. Searches the request
//            vector starting at startIndex (round-robin) or at 0 (fixed)
//            and returns a one-hot grant plus its index.
// Revision : 1.0 - initial release
// ============================================================================
module evg_rr_picker
  import evg_event_pkg::*;
#(
  parameter int REQ_COUNT = 4,
  localparam int IDX_WIDTH = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1
) (
  input  logic [REQ_COUNT-1:0] request,
  input  logic [IDX_WIDTH-1:0] startIndex,
  input  arbMode_t             mode,
  output logic [REQ_COUNT-1:0] grant,
  output logic [IDX_WIDTH-1:0] grantIndex,
  output logic                 grantValid
);

  localparam logic [IDX_WIDTH:0] c_reqCount = (IDX_WIDTH+1)'(REQ_COUNT);

  logic [IDX_WIDTH-1:0] w_base;
  logic [IDX_WIDTH:0]   w_sum;
  logic [IDX_WIDTH-1:0] w_idx;

  // First requester found walking upward (with wrap) from the base index
  always_comb begin
    grant      = '0;
    grantIndex = '0;
    grantValid = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    w_base     = (mode == ARB_ROUND_ROBIN) ? startIndex : '0;
    for (int k = 0; k < REQ_COUNT; k++) begin
      w_sum = {1'b0, w_base} + (IDX_WIDTH+1)'(k);
      if (w_sum >= c_reqCount) begin
        w_sum = w_sum - c_reqCount;
      end
      w_idx = w_sum[IDX_WIDTH-1:0];
      if (!grantValid && request[w_idx]) begin
        grantValid    = 1'b1;
        grantIndex    = w_idx;
        grant[w_idx]  = 1'b1;
      end
    end
  end

endmodule : evg_rr_picker
`default_nettype wire

// File: rtl/evg_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : evg_event_arbiter
// Purpose  : Merges the non-stallable sequencer event stream with
//            SOURCE_COUNT handshaked event sources into one registered
//            event-code stream. Fixed-priority or round-robin source
//            arbitration, per-source enable, null-code drop and a saturating
//            count of sequencer preemptions.
// Revision : 1.0 - initial release
// ============================================================================
module evg_event_arbiter
  import evg_event_pkg::*;
#(
  parameter int SOURCE_COUNT    = 4,
  parameter int EVENTCODE_WIDTH = evg_event_pkg::EVENTCODE_WIDTH,
  parameter int COUNTER_WIDTH   = 16,
  localparam int GRANT_WIDTH    = $clog2(SOURCE_COUNT + 1)
) (
  input  logic                                    evgTxClk,
  input  logic                                    evgTxReset,
  input  logic [EVENTCODE_WIDTH-1:0]              evgSequenceEventTDATA,
  input  logic                                    evgSequenceEventTVALID,
  input  logic [SOURCE_COUNT*EVENTCODE_WIDTH-1:0] srcTDATA,
  input  logic [SOURCE_COUNT-1:0]                 srcTVALID,
  output logic [SOURCE_COUNT-1:0]                 srcTREADY,
  input  logic [SOURCE_COUNT-1:0]                 srcEnable,
  input  logic                                    roundRobin,
  output logic [EVENTCODE_WIDTH-1:0]              evgEventCode,
  output logic                                    evgEventValid,
  output logic [GRANT_WIDTH-1:0]                  evgGrantIndex,
  output logic [COUNTER_WIDTH-1:0]                preemptCount
);

  localparam int IDX_WIDTH = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1;
  localparam logic [IDX_WIDTH:0]       c_srcCount  = (IDX_WIDTH+1)'(SOURCE_COUNT);
  localparam logic [GRANT_WIDTH-1:0]   c_seqIndex  = GRANT_WIDTH'(SOURCE_COUNT);
  localparam logic [IDX_WIDTH-1:0]     c_lastReset = IDX_WIDTH'(SOURCE_COUNT - 1);

  // Registers
  logic [EVENTCODE_WIDTH-1:0] r_eventCode;
  logic                       r_eventValid;
  logic [GRANT_WIDTH-1:0]     r_grantIndex;
  logic [COUNTER_WIDTH-1:0]   r_preemptCount;
  logic [IDX_WIDTH-1:0]       r_lastGrant;

  // Decision wires
  logic [SOURCE_COUNT-1:0]    w_eligible;
  logic [SOURCE_COUNT-1:0]    w_nullReq;
  logic [SOURCE_COUNT-1:0]    w_codeReq;
  logic                       w_seqActive;
  logic [IDX_WIDTH:0]         w_startSum;
  logic [IDX_WIDTH-1:0]       w_startIndex;
  logic [SOURCE_COUNT-1:0]    w_pickGrant;
  logic [IDX_WIDTH-1:0]       w_pickIndex;
  logic                       w_pickValid;
  logic [EVENTCODE_WIDTH-1:0] w_pickCode;

  // Classify each source as null (consumed silently) or carrying an event
  for (genvar i = 0; i < SOURCE_COUNT; i++) begin : g_srcClass
    assign w_eligible[i] = srcTVALID[i] & srcEnable[i];
    assign w_nullReq[i]  = w_eligible[i] &
                           (srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH] == '0);
    assign w_codeReq[i]  = w_eligible[i] &
                           (srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH] != '0);
  end

  assign w_seqActive = evgSequenceEventTVALID & (evgSequenceEventTDATA != '0);

  // Round-robin search begins one past the last source granted, with wrap
  always_comb begin
    w_startSum = {1'b0, r_lastGrant} + (IDX_WIDTH+1)'(1);
    if (w_startSum >= c_srcCount) begin
      w_startSum = '0;
    end
    w_startIndex = w_startSum[IDX_WIDTH-1:0];
  end

  evg_rr_picker #(
    .REQ_COUNT (SOURCE_COUNT)
  ) u_picker (
    .request    (w_codeReq),
    .startIndex (w_startIndex),
    .mode       (arbMode_t'(roundRobin)),
    .grant      (w_pickGrant),
    .grantIndex (w_pickIndex),
    .grantValid (w_pickValid)
  );

  // Code of the picked source, selected through the one-hot grant
  always_comb begin
    w_pickCode = '0;
    for (int i = 0; i < SOURCE_COUNT; i++) begin
      if (w_pickGrant[i]) begin
        w_pickCode = w_pickCode | srcTDATA[i*EVENTCODE_WIDTH +: EVENTCODE_WIDTH];
      end
    end
  end

  // Nulls are always drained; event-carrying sources only when the sequencer is quiet
  always_comb begin
    if (evgTxReset) begin
      srcTREADY = '0;
    end else begin
      srcTREADY = w_nullReq | (w_seqActive ? '0 : w_pickGrant);
    end
  end

  // Output register, round-robin pointer and preemption counter
  always_ff @(posedge evgTxClk or posedge evgTxReset) begin
    if (evgTxReset) begin
      r_eventCode    <= '0;
      r_eventValid   <= 1'b0;
      r_grantIndex   <= '0;
      r_preemptCount <= '0;
      r_lastGrant    <= c_lastReset;
    end else if (w_seqActive) begin
      r_eventCode  <= evgSequenceEventTDATA;
      r_eventValid <= 1'b1;
      r_grantIndex <= c_seqIndex;
      if ((|w_codeReq) && (r_preemptCount != '1)) begin
        r_preemptCount <= r_preemptCount + 1'b1;
      end
    end else if (w_pickValid) begin
      r_eventCode  <= w_pickCode;
      r_eventValid <= 1'b1;
      r_grantIndex <= GRANT_WIDTH'(w_pickIndex);
      r_lastGrant  <= w_pickIndex;
    end else begin
      r_eventCode  <= '0;
      r_eventValid <= 1'b0;
    end
  end

  assign evgEventCode  = r_eventCode;
  assign evgEventValid = r_eventValid;
  assign evgGrantIndex = r_grantIndex;
  assign preemptCount  = r_preemptCount;

endmodule : evg_event_arbiter
`default_nettype wire

// File: doc/evg_event_arbiter.md
# evg_event_arbiter

Parametrised successor to the fixed three-source event merge in the event generator transmit path. Merges one non-stallable sequencer event stream and `SOURCE_COUNT` handshaked event sources into a single registered event-code stream. The output feeds the transmitter's event byte, one event per `evgTxClk` cycle. Adds a run-time selectable fixed-priority or round-robin mode, a per-source enable mask, null-code filtering and a saturating preemption counter.

## Interface
- `SOURCE_COUNT`, 4: number of handshaked sources; legal range 1–16.
- `EVENTCODE_WIDTH`, 8: event code width.
- `COUNTER_WIDTH`, 16: width of the preemption counter.

Ports:
- `evgTxClk`  in  1  sole clock.
- `evgTxReset`  in  1  asynchronous, active-high reset.
- `evgSequenceEventTDATA`  in  `EVENTCODE_WIDTH`  sequencer event code.
- `evgSequenceEventTVALID`  in  1  sequencer event present; has no ready, so it is never stalled.
- `srcTDATA`  in  `SOURCE_COUNT*EVENTCODE_WIDTH`  source codes; source i occupies bits [i*W +: W].
- `srcTVALID`  in  `SOURCE_COUNT`  per-source valid.
- `srcTREADY`  out  `SOURCE_COUNT`  per-source ready (combinational).
- `srcEnable`  in  `SOURCE_COUNT`  per-source enable mask.
- `roundRobin`  in  1  1 = round-robin arbitration, 0 = fixed priority (index 0 highest).
- `evgEventCode`  out  `EVENTCODE_WIDTH`  registered output code; 0 when idle.
- `evgEventValid`  out  1  registered; 1 when `evgEventCode` carries an event.
- `evgGrantIndex`  out  `$clog2(SOURCE_COUNT+1)`  registered; index of the granted source, `SOURCE_COUNT` = sequencer.
- `preemptCount`  out  `COUNTER_WIDTH`  saturating count of cycles in which the sequencer displaced a pending source.

## Operation
- **Transfer rule.** A source transfer occurs when `srcTVALID[i] & srcTREADY[i]` in a cycle.
- **Eligibility.** Source i is eligible when `srcTVALID[i] & srcEnable[i]`.
- **Null codes.**
  - An eligible source presenting code 0 is null. It gets `srcTREADY[i]=1` in the same cycle and is consumed.
  - A null consumption produces no output and does not move the round-robin pointer.
  - Several null sources are consumed simultaneously.
- **Per-cycle priority.**
  1. Sequencer valid with nonzero code → it is output. Every `srcTREADY` for nonzero codes is 0. If any eligible nonzero source exists, `preemptCount` increments (saturating at all-ones).
  2. Otherwise, at most one eligible nonzero source is granted (`srcTREADY=1`), chosen by the active mode.
  3. Otherwise the output is idle: code 0, valid 0, grant index unchanged.
- **Sequencer code 0** is treated as no sequencer event.
- **Fixed priority mode.** The lowest eligible index wins.
- **Round-robin mode.**
  - The search starts at `lastGrant+1` modulo `SOURCE_COUNT`.
  - `lastGrant` updates only on a nonzero source grant. Sequencer cycles do not move it.
- **Mode change.** A `roundRobin` change takes effect on the next cycle's decision. `lastGrant` is retained across mode changes.
- **Disabled sources.** A disabled source always sees `srcTREADY=0` and its pending data is held, not dropped. Clearing an enable bit mid-packet is legal.
- **Reset values.**
  - `evgEventCode=0`, `evgEventValid=0`, `evgGrantIndex=0`, `preemptCount=0`.
  - `lastGrant=SOURCE_COUNT-1`, so source 0 is searched first after reset.
- **`srcTREADY` during reset** is forced to 0.

## Timing
- **Latency.** Exactly one `evgTxClk` cycle from the transfer cycle (or sequencer-valid cycle) to `evgEventCode`/`evgEventValid`.
- **Throughput.** One event per cycle sustained. A source with continuous valid and no competition is granted every cycle.
- **Fairness.** In round-robin mode with k continuously eligible sources and no sequencer traffic, each is granted exactly once per k cycles.
- **Ready path.** `srcTREADY` is combinational from `srcTVALID`, `srcTDATA`, `srcEnable`, `roundRobin`, the sequencer inputs and `lastGrant`. `srcTREADY` never depends on a source's own TREADY, so there is no loop.
- **Reset.** Assertion clears all registers immediately. Deassertion is synchronised externally; the first decision occurs in the first clock edge after release.
- **Counter saturation.** `preemptCount` holds at `2^COUNTER_WIDTH-1` and never wraps.

## Structure
- Package `evg_event_pkg`:
  - `EVENTCODE_WIDTH` default.
  - `EVCODE_NULL = 0`.
  - Event-code typedef.
  - Shared constants, also to be used by the sequencer and trigger blocks.
- Sub-module `evg_rr_picker`: combinational rotate-and-priority-encode.
  - Inputs: request vector, start index, mode.
  - Outputs: one-hot grant and grant index.
  - The top level owns all registers: output, `lastGrant`, counter.

## Test plan
- **Fixed priority.** `roundRobin=0`, sources 0/2 valid with 0x10/0x20, all enabled. Expected: cycle 1 outputs 0x10 with grant 0; cycle 2 outputs 0x20 with grant 2; `srcTREADY[2]` low in the first decision.
- **Round-robin fairness.** `roundRobin=1`, sources 0–3 continuously valid with codes 0x01–0x04. Expected: output sequence 01,02,03,04,01… from reset; each source granted 25 times in 100 cycles.
- **Sequencer preemption.** Sequencer 0x7D for 3 cycles while source 1 holds 0x55. Expected: output 7D×3 then 55; `preemptCount=3`; source 1 data unchanged until accepted.
- **Null and disabled handling.** Source 0 presents 0x00, source 3 presents 0x33 with `srcEnable[3]=0`. Expected: source 0 consumed, output idle; source 3 ready stays 0. After enabling source 3, 0x33 appears one cycle later.
- **Counter saturation and reset.** Use `COUNTER_WIDTH=4` with 20 preemption cycles. Expected: counter holds 15. Asserting reset mid-burst clears every output to 0 within the same cycle; after release the round-robin search restarts at source 0.
